// File: rtl/rob_commit_ctrl.sv
// Purpose : in-order reorder buffer; allocates tags, takes CDB results, retires the head into RegFile, flushes on a mispredicted head.
// Latency : CDB write at edge E marks an entry ready; its commit is registered at E+1 (one commit per cycle max); operand lookup is combinational.
// Backpressure: full_to_dsp refuses allocation when all entries are in use or during the rollback output cycle; no bypass through a same-edge commit.
//
// Ports:
//   clk, rst                          clock / asynchronous active-high reset
//   alloc_from_dsp, rd_from_dsp       allocation request and its destination register
//   rob_id_to_dsp, full_to_dsp        tag for the next allocation, allocation refused
//   Q1/Q2_from_dsp                    operand tags to look up
//   ready1/2_to_dsp, V1/V2_to_dsp     operand availability and value (0 when not ready)
//   valid/Q/V/mispred_from_cdb        common data bus broadcast
//   commit_flag_to_rf, rollback_flag_to_rf, rd_to_rf, Q_to_rf, V_to_rf   registered commit port
module rob_commit_ctrl #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_ID_W = 5,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_from_dsp,
    input  logic [REG_W-1:0]    rd_from_dsp,
    output logic [ROB_ID_W-1:0] rob_id_to_dsp,
    output logic                full_to_dsp,
    input  logic [ROB_ID_W-1:0] Q1_from_dsp,
    input  logic [ROB_ID_W-1:0] Q2_from_dsp,
    output logic                ready1_to_dsp,
    output logic                ready2_to_dsp,
    output logic [DATA_W-1:0]   V1_to_dsp,
    output logic [DATA_W-1:0]   V2_to_dsp,
    input  logic                valid_from_cdb,
    input  logic [ROB_ID_W-1:0] Q_from_cdb,
    input  logic [DATA_W-1:0]   V_from_cdb,
    input  logic                mispred_from_cdb,
    output logic                commit_flag_to_rf,
    output logic                rollback_flag_to_rf,
    output logic [REG_W-1:0]    rd_to_rf,
    output logic [ROB_ID_W-1:0] Q_to_rf,
    output logic [DATA_W-1:0]   V_to_rf
);

    localparam int PTR_W = $clog2(ROB_SIZE);
    localparam logic [ROB_ID_W-1:0] ZERO_ROB = '0;

    // Per-entry control bits live in reset flops; rd/value are plain storage
    // because they are only ever observed through a busy entry.
    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_mispred;
    logic [REG_W-1:0]    r_rd  [ROB_SIZE];
    logic [DATA_W-1:0]   r_val [ROB_SIZE];

    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [ROB_ID_W-1:0] r_count;

    logic                w_alloc;
    logic                w_commit;
    logic                w_flush;
    logic                w_cdb_wr;
    logic [PTR_W-1:0]    w_cdb_idx;

    // Tags are index+1; anything outside 1..ROB_SIZE names no entry.
    function automatic logic tag_valid(input logic [ROB_ID_W-1:0] tag);
        return (tag != ZERO_ROB) && (tag <= ROB_ID_W'(ROB_SIZE));
    endfunction

    function automatic logic [PTR_W-1:0] tag_idx(input logic [ROB_ID_W-1:0] tag);
        return PTR_W'(tag - ROB_ID_W'(1));
    endfunction

    // Returns {ready, value} for one operand port.
    function automatic logic [DATA_W:0] lookup(input logic [ROB_ID_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        if (tag == ZERO_ROB) begin
            res = '0;
        end else if (valid_from_cdb && (Q_from_cdb == tag)) begin
            res = {1'b1, V_from_cdb};
        end else if (tag_valid(tag) && r_busy[tag_idx(tag)] && r_ready[tag_idx(tag)]) begin
            res = {1'b1, r_val[tag_idx(tag)]};
        end
        return res;
    endfunction

    assign full_to_dsp   = (r_count == ROB_ID_W'(ROB_SIZE)) || rollback_flag_to_rf;
    assign rob_id_to_dsp = ROB_ID_W'(r_tail) + ROB_ID_W'(1);

    assign w_alloc   = alloc_from_dsp && !full_to_dsp;
    assign w_commit  = r_busy[r_head] && r_ready[r_head];
    assign w_flush   = w_commit && r_mispred[r_head];
    assign w_cdb_idx = tag_idx(Q_from_cdb);
    assign w_cdb_wr  = valid_from_cdb && tag_valid(Q_from_cdb) && r_busy[w_cdb_idx];

    always_comb begin
        ready1_to_dsp = 1'b0;
        V1_to_dsp     = '0;
        ready2_to_dsp = 1'b0;
        V2_to_dsp     = '0;
        {ready1_to_dsp, V1_to_dsp} = lookup(Q1_from_dsp);
        {ready2_to_dsp, V2_to_dsp} = lookup(Q2_from_dsp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy              <= '0;
            r_ready             <= '0;
            r_mispred           <= '0;
            r_head              <= '0;
            r_tail              <= '0;
            r_count             <= '0;
            commit_flag_to_rf   <= 1'b0;
            rollback_flag_to_rf <= 1'b0;
            rd_to_rf            <= '0;
            Q_to_rf             <= '0;
            V_to_rf             <= '0;
        end else begin
            commit_flag_to_rf   <= w_commit;
            rollback_flag_to_rf <= w_flush;
            if (w_commit) begin
                rd_to_rf <= r_rd[r_head];
                Q_to_rf  <= ROB_ID_W'(r_head) + ROB_ID_W'(1);
                V_to_rf  <= r_val[r_head];
            end

            if (w_flush) begin
                // Mispredicted head: everything younger is squashed, and any
                // allocation or CDB write at this edge is discarded with it.
                r_busy    <= '0;
                r_ready   <= '0;
                r_mispred <= '0;
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
            end else begin
                if (w_cdb_wr) begin
                    r_ready[w_cdb_idx]   <= 1'b1;
                    r_mispred[w_cdb_idx] <= mispred_from_cdb;
                end
                // Tail and head can only coincide when empty (no commit) or
                // full (no alloc), so these two writes never collide.
                if (w_alloc) begin
                    r_busy[r_tail]    <= 1'b1;
                    r_ready[r_tail]   <= 1'b0;
                    r_mispred[r_tail] <= 1'b0;
                    r_tail            <= r_tail + PTR_W'(1);
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + PTR_W'(1);
                end
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + ROB_ID_W'(1);
                    2'b01:   r_count <= r_count - ROB_ID_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage; stale writes on a flush edge are harmless since the
    // entries are no longer busy.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rd[r_tail] <= rd_from_dsp;
        end
        if (w_cdb_wr) begin
            r_val[w_cdb_idx] <= V_from_cdb;
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
module tb_rob_commit_ctrl;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_from_dsp = 1'b0;
    logic [4:0]  rd_from_dsp = '0;
    logic [4:0]  rob_id_to_dsp;
    logic        full_to_dsp;
    logic [4:0]  Q1_from_dsp = '0;
    logic [4:0]  Q2_from_dsp = '0;
    logic        ready1_to_dsp, ready2_to_dsp;
    logic [31:0] V1_to_dsp, V2_to_dsp;
    logic        valid_from_cdb = 1'b0;
    logic [4:0]  Q_from_cdb = '0;
    logic [31:0] V_from_cdb = '0;
    logic        mispred_from_cdb = 1'b0;
    logic        commit_flag_to_rf, rollback_flag_to_rf;
    logic [4:0]  rd_to_rf;
    logic [4:0]  Q_to_rf;
    logic [31:0] V_to_rf;

    always #5 clk = ~clk;

    rob_commit_ctrl #(.ROB_SIZE(16), .ROB_ID_W(5), .DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .alloc_from_dsp(alloc_from_dsp), .rd_from_dsp(rd_from_dsp),
        .rob_id_to_dsp(rob_id_to_dsp), .full_to_dsp(full_to_dsp),
        .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
        .ready1_to_dsp(ready1_to_dsp), .ready2_to_dsp(ready2_to_dsp),
        .V1_to_dsp(V1_to_dsp), .V2_to_dsp(V2_to_dsp),
        .valid_from_cdb(valid_from_cdb), .Q_from_cdb(Q_from_cdb),
        .V_from_cdb(V_from_cdb), .mispred_from_cdb(mispred_from_cdb),
        .commit_flag_to_rf(commit_flag_to_rf), .rollback_flag_to_rf(rollback_flag_to_rf),
        .rd_to_rf(rd_to_rf), .Q_to_rf(Q_to_rf), .V_to_rf(V_to_rf)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: the ROB as an ordered list of in-flight instructions.
    typedef struct {
        int          tag;
        int          rd;
        bit          rdy;
        bit          mp;
        logic [31:0] v;
    } ent_t;

    ent_t        q[$];
    int          next_tag;
    bit          e_cf, e_rb;
    int          e_rd, e_q;
    logic [31:0] e_v;

    task automatic m_reset();
        q.delete();
        next_tag = 1;
        e_cf = 0; e_rb = 0; e_rd = 0; e_q = 0; e_v = '0;
    endtask

    task automatic m_look(input int tag, output bit r, output logic [31:0] v);
        r = 0; v = '0;
        if (tag == 0) return;
        if (valid_from_cdb && int'(Q_from_cdb) == tag) begin
            r = 1; v = V_from_cdb;
            return;
        end
        foreach (q[i]) if (q[i].tag == tag && q[i].rdy) begin r = 1; v = q[i].v; end
    endtask

    // State change at one rising edge, computed from the pre-edge state.
    task automatic m_edge();
        bit full_now;
        full_now = (q.size() == N) || e_rb;
        if (q.size() > 0 && q[0].rdy) begin
            e_cf = 1; e_rd = q[0].rd; e_q = q[0].tag; e_v = q[0].v; e_rb = q[0].mp;
            q.delete(0);
            if (e_rb) begin
                q.delete();
                next_tag = 1;
                return;
            end
        end else begin
            e_cf = 0; e_rb = 0;
        end
        if (valid_from_cdb && Q_from_cdb != 0)
            foreach (q[i]) if (q[i].tag == int'(Q_from_cdb)) begin
                q[i].rdy = 1; q[i].v = V_from_cdb; q[i].mp = mispred_from_cdb;
            end
        if (alloc_from_dsp && !full_now) begin
            q.push_back('{next_tag, int'(rd_from_dsp), 1'b0, 1'b0, 32'h0});
            next_tag = (next_tag == N) ? 1 : next_tag + 1;
        end
    endtask

    task automatic set_in(input bit a, input int rd, input bit cv, input int cq,
                          input logic [31:0] cval, input bit mp, input int l1, input int l2);
        alloc_from_dsp   = a;
        rd_from_dsp      = 5'(rd);
        valid_from_cdb   = cv;
        Q_from_cdb       = 5'(cq);
        V_from_cdb       = cval;
        mispred_from_cdb = mp;
        Q1_from_dsp      = 5'(l1);
        Q2_from_dsp      = 5'(l2);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic cycle();
        bit          r;
        logic [31:0] v;
        #1;
        check("full", full_to_dsp, (q.size() == N) || e_rb);
        check("rob_id", rob_id_to_dsp, next_tag);
        m_look(int'(Q1_from_dsp), r, v);
        check("ready1", ready1_to_dsp, r);
        check("V1", V1_to_dsp, v);
        m_look(int'(Q2_from_dsp), r, v);
        check("ready2", ready2_to_dsp, r);
        check("V2", V2_to_dsp, v);
        m_edge();
        @(posedge clk);
        #1;
        check("commit_flag", commit_flag_to_rf, e_cf);
        check("rollback_flag", rollback_flag_to_rf, e_rb);
        check("rd_to_rf", rd_to_rf, e_rd);
        check("Q_to_rf", Q_to_rf, e_q);
        check("V_to_rf", V_to_rf, e_v);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        check("rst_commit", commit_flag_to_rf, 0);
        check("rst_rollback", rollback_flag_to_rf, 0);
        check("rst_rd", rd_to_rf, 0);
        check("rst_Q", Q_to_rf, 0);
        check("rst_V", V_to_rf, 0);
        check("rst_full", full_to_dsp, 0);
        check("rst_rob_id", rob_id_to_dsp, 1);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cq, l1, l2;
        m_reset();
        #1;
        do_reset();

        // Single instruction end to end.
        set_in(1, 5, 0, 0, 0, 0, 0, 0); cycle();
        set_in(0, 0, 1, 1, 32'h1234, 0, 0, 0); cycle();
        idle(); cycle();
        check("t1_commit", commit_flag_to_rf, 1);
        check("t1_rd", rd_to_rf, 5);
        check("t1_Q", Q_to_rf, 1);
        check("t1_V", V_to_rf, 32'h1234);
        idle(); cycle();
        check("t1_pulse", commit_flag_to_rf, 0);

        // Fill, overflow attempt, free one, wrap.
        do_reset();
        for (int i = 0; i < N; i++) begin set_in(1, i, 0, 0, 0, 0, 0, 0); cycle(); end
        check("t2_full", full_to_dsp, 1);
        set_in(1, 31, 0, 0, 0, 0, 0, 0); cycle();
        set_in(1, 30, 1, 1, 32'hAAAA, 0, 1, 16); cycle();
        set_in(1, 29, 0, 0, 0, 0, 0, 0); cycle();
        check("t2_full_drop", full_to_dsp, 0);
        check("t2_wrap_tag", rob_id_to_dsp, 1);
        set_in(1, 7, 0, 0, 0, 0, 0, 0); cycle();
        check("t2_after_wrap", rob_id_to_dsp, 2);

        // Out-of-order completion, in-order commit.
        do_reset();
        for (int i = 0; i < 3; i++) begin set_in(1, 10 + i, 0, 0, 0, 0, 0, 0); cycle(); end
        set_in(0, 0, 1, 3, 32'h33, 0, 0, 0); cycle();
        set_in(0, 0, 1, 2, 32'h22, 0, 3, 0); cycle();
        set_in(0, 0, 1, 1, 32'h11, 0, 2, 3); cycle();
        for (int i = 0; i < 4; i++) begin idle(); cycle(); end

        // Mispredicted branch at tag 2.
        do_reset();
        for (int i = 0; i < 4; i++) begin set_in(1, 20 + i, 0, 0, 0, 0, 0, 0); cycle(); end
        set_in(0, 0, 1, 1, 32'h100, 0, 0, 0); cycle();
        set_in(0, 0, 1, 2, 32'h200, 1, 0, 0); cycle();
        idle(); cycle();
        check("t4_rollback", rollback_flag_to_rf, 1);
        check("t4_Q", Q_to_rf, 2);
        check("t4_full", full_to_dsp, 1);
        check("t4_rob_id", rob_id_to_dsp, 1);
        set_in(1, 9, 1, 3, 32'h300, 0, 3, 0); cycle();
        check("t4_no_commit", commit_flag_to_rf, 0);
        for (int i = 0; i < 3; i++) begin idle(); cycle(); end

        // Same-cycle CDB bypass on lookup.
        do_reset();
        set_in(1, 1, 0, 0, 0, 0, 0, 0); cycle();
        set_in(1, 2, 0, 0, 0, 0, 0, 0); cycle();
        set_in(0, 0, 1, 2, 32'd7, 0, 2, 0);
        #1;
        check("t5_ready1", ready1_to_dsp, 1);
        check("t5_V1", V1_to_dsp, 7);
        check("t5_ready2", ready2_to_dsp, 0);
        check("t5_V2", V2_to_dsp, 0);
        cycle();

        // Reset while five entries are busy and the head is ready.
        do_reset();
        for (int i = 0; i < 6; i++) begin set_in(1, i + 1, 0, 0, 0, 0, 0, 0); cycle(); end
        set_in(0, 0, 1, 1, 32'hBEEF, 0, 0, 0); cycle();
        set_in(0, 0, 1, 2, 32'hCAFE, 0, 0, 0); cycle();
        check("t6_pre_commit", commit_flag_to_rf, 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin idle(); cycle(); end

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (q.size() > 0 && $urandom_range(0, 7) != 0) cq = q[$urandom_range(0, q.size() - 1)].tag;
            else cq = $urandom_range(0, 17);
            l1 = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[$urandom_range(0, q.size() - 1)].tag
                                                              : $urandom_range(0, 17);
            l2 = $urandom_range(0, 17);
            set_in($urandom_range(0, 4) < 3, $urandom_range(0, 31), $urandom_range(0, 1) == 1, cq,
                   $urandom, $urandom_range(0, 15) == 0, l1, l2);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
